// File: rtl/pl_muldiv_sched.sv
// pl_muldiv_sched: iterative MULT/MULTU/DIV/DIVU sequencer that owns HI/LO.
// A started op runs IDLE -> PREP -> RUN (N cycles) -> FIX, where
// N = WIDTH/BITS_PER_CYC. RUN does shift-add multiply or restoring divide on
// operand magnitudes; FIX restores the signs and writes HI/LO.
// md_stall holds any MF/MT/MD instruction in ID while a sequence is in flight.
// Build option MD_DIV0_EXC_EN: a divide by zero is caught in PREP, pulses div0
// and returns to IDLE without touching HI/LO (adds the div0 port).
module pl_muldiv_sched #(
  parameter int WIDTH        = 32,
  parameter int BITS_PER_CYC = 1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wd,
  input  logic             rd_req,
  output logic             busy,
  output logic             md_stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MD_DIV0_EXC_EN
  ,
  output logic             div0
`endif
);

  localparam int            N      = WIDTH / BITS_PER_CYC;
  localparam int            CW     = $clog2(N + 1);
  localparam logic [CW-1:0] N_LOAD = CW'(N);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q;      // op[1]: divide, op[0]: signed
  logic [WIDTH-1:0]   a_q, b_q;  // operands as issued
  logic [WIDTH-1:0]   opnd_q;    // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q;     // {partial hi, lo} or {remainder, quotient}
  logic               neg_p_q;   // product / quotient is negative
  logic               neg_r_q;   // remainder is negative (dividend sign)
  logic [CW-1:0]      cnt_q;

  logic               is_div;
  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               div0_hit;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH:0]   wide;
  logic [WIDTH:0]     diff;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign is_div = op_q[1];

  // Operand magnitudes, result signs and divide-by-zero detect for PREP.
  always_comb begin
    sa       = op_q[0] & a_q[WIDTH-1];
    sb       = op_q[0] & b_q[WIDTH-1];
    mag_a    = sa ? -a_q : a_q;
    mag_b    = sb ? -b_q : b_q;
    div0_hit = is_div && (b_q == '0);
  end

  // One RUN cycle: BITS_PER_CYC single-bit multiply or restoring-divide steps.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    step_acc = acc_q;
    wide     = '0;
    diff     = '0;
    sum      = '0;
    for (int i = 0; i < BITS_PER_CYC; i++) begin
      if (is_div) begin
        // Shift {rem, quot} left; try to subtract the divisor from the new rem.
        wide = {step_acc, 1'b0};
        diff = wide[2*WIDTH:WIDTH] - {1'b0, opnd_q};
        if (!diff[WIDTH])
          step_acc = {diff[WIDTH-1:0], wide[WIDTH-1:1], 1'b1};
        else
          step_acc = {wide[2*WIDTH-1:WIDTH], wide[WIDTH-1:1], 1'b0};
      end else begin
        // Add the multiplicand on a set multiplier bit, then shift right.
        sum      = {1'b0, step_acc[2*WIDTH-1:WIDTH]}
                 + (step_acc[0] ? {1'b0, opnd_q} : '0);
        step_acc = {sum, step_acc[WIDTH-1:1]};
      end
    end
  end

  // Sign restoration applied in FIX.
  always_comb begin
    prod_fix = neg_p_q ? -acc_q : acc_q;
    q_fix    = neg_p_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    r_fix    = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (is_div) begin
      res_hi = r_fix;
      res_lo = q_fix;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge clrn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!clrn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state and status outputs.
  always_comb begin
    state_d  = state_q;
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_FIX);
    md_stall = busy & (start | rd_req | mthi | mtlo);
`ifdef MD_DIV0_EXC_EN
    div0     = (state_q == S_PREP) && div0_hit;
`endif
    case (state_q)
      S_IDLE: if (start) state_d = S_PREP;
      S_PREP: begin
`ifdef MD_DIV0_EXC_EN
        if (div0_hit) state_d = S_IDLE;
        else          state_d = S_RUN;
`else
        state_d = S_RUN;
`endif
      end
      S_RUN:  if (cnt_q == CW'(1)) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Working registers: latch on start, set up in PREP, iterate in RUN.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      neg_p_q <= 1'b0;
      neg_r_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          op_q <= op;
          a_q  <= a;
          b_q  <= b;
        end
        S_PREP: begin
          opnd_q  <= is_div ? mag_b : mag_a;
          acc_q   <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
          neg_p_q <= sa ^ sb;
          neg_r_q <= sa;
          cnt_q   <= N_LOAD;
        end
        S_RUN: begin
          acc_q <= step_acc;
          cnt_q <= cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // HI/LO: result at the end of FIX; MTHI/MTLO only when idle and not starting.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      hi <= '0;
      lo <= '0;
    end else if (state_q == S_FIX) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (state_q == S_IDLE && !start) begin
      if (mthi) hi <= wd;
      if (mtlo) lo <= wd;
    end
  end

endmodule

// File: tb/tb_pl_muldiv_sched.sv
// tb_pl_muldiv_sched: directed vectors with hand-computed results for the
// default build (WIDTH=32, BITS_PER_CYC=1, divide by zero runs to completion).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pl_muldiv_sched;

  logic        clk = 1'b0;
  logic        clrn;
  logic        start, mthi, mtlo, rd_req;
  logic [1:0]  op;
  logic [31:0] a, b, wd;
  logic        busy, md_stall, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;
  localparam int         LAT      = 34;

  always #5 clk = ~clk;

  pl_muldiv_sched dut (
    .clk      (clk),
    .clrn     (clrn),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .mthi     (mthi),
    .mtlo     (mtlo),
    .wd       (wd),
    .rd_req   (rd_req),
    .busy     (busy),
    .md_stall (md_stall),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op (optionally with MTHI in the same cycle), wait for done with a
  // bound, check latency, and return on the cycle after done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic with_mthi, input logic [31:0] mt_data, input string tag);
    int k;
    logic [31:0] hi_before;
    @(negedge clk);
    hi_before = hi;
    start = 1'b1; op = o; a = x; b = y; mthi = with_mthi; wd = mt_data;
    k = 0;
    do begin
      @(negedge clk);
      start = 1'b0; mthi = 1'b0;
      k++;
      if (k == 1) begin
        #1;
        check({tag, " hi held"}, 64'(hi), 64'(hi_before));
        check({tag, " busy"}, 64'(busy), 64'd1);
      end
    end while (!done && k < 100);
    check({tag, " latency"}, 64'(k), 64'(LAT));
    @(negedge clk);
    #1;
    check({tag, " busy after"}, 64'(busy), 64'd0);
  endtask

  task automatic expect_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    int k;
    int stall_cnt;
    clrn = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; rd_req = 1'b0;
    op = '0; a = '0; b = '0; wd = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst md_stall", 64'(md_stall), 64'd0);
    expect_hilo("rst", 32'h0, 32'h0);
    clrn = 1'b1;

    // MTLO / MTHI while idle
    @(negedge clk); mtlo = 1'b1; wd = 32'h1234_5678;
    @(negedge clk); mtlo = 1'b0; #1;
    check("mtlo", 64'(lo), 64'h1234_5678);
    @(negedge clk); mthi = 1'b1; wd = 32'hA5A5_A5A5;
    @(negedge clk); mthi = 1'b0; #1;
    check("mthi", 64'(hi), 64'hA5A5_A5A5);

    // start + mthi together: MT write dropped, result lands
    run_op(OP_MULTU, 32'd2, 32'd3, 1'b1, 32'hDEAD_BEEF, "start+mthi");
    expect_hilo("start+mthi", 32'h0, 32'd6);

    // Largest unsigned product
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, "multu max");
    expect_hilo("multu max", 32'hFFFF_FFFE, 32'h0000_0001);

    // Reset in RUN cycle 10 of a DIVU aborts the op and clears HI/LO at once
    @(negedge clk); start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd7;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk); start = 1'b0;
    end
    clrn = 1'b0; #1;
    check("abort busy", 64'(busy), 64'd0);
    expect_hilo("abort", 32'h0, 32'h0);
    @(negedge clk); clrn = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("abort stays idle", 64'(busy), 64'd0);
    expect_hilo("abort after", 32'h0, 32'h0);
    run_op(OP_MULTU, 32'd6, 32'd7, 1'b0, 32'h0, "multu 6*7");
    expect_hilo("multu 6*7", 32'h0, 32'd42);

    // Signed and unsigned arithmetic
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h0, "div -7/2");
    expect_hilo("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 32'h0, "mult -3*5");
    expect_hilo("mult -3*5", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'h0, "div 7/-2");
    expect_hilo("div 7/-2", 32'h0000_0001, 32'hFFFF_FFFD);
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 32'h0, "divu 100/7");
    expect_hilo("divu 100/7", 32'd2, 32'd14);
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, "mult min*min");
    expect_hilo("mult min*min", 32'h4000_0000, 32'h0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, "div min/-1");
    expect_hilo("div min/-1", 32'h0, 32'h8000_0000);

    // Divide by zero runs to completion
    run_op(OP_DIVU, 32'd9, 32'd0, 1'b0, 32'h0, "divu 9/0");
    expect_hilo("divu 9/0", 32'd9, 32'hFFFF_FFFF);
    run_op(OP_DIV, 32'hFFFF_FFF7, 32'd0, 1'b0, 32'h0, "div -9/0");
    expect_hilo("div -9/0", 32'hFFFF_FFF7, 32'h0000_0001);
    run_op(OP_DIV, 32'd9, 32'd0, 1'b0, 32'h0, "div 9/0");
    expect_hilo("div 9/0", 32'd9, 32'hFFFF_FFFF);

    // rd_req from cycle 5 stalls until busy falls; a start while busy is ignored
    @(negedge clk); start = 1'b1; op = OP_MULTU; a = 32'd100; b = 32'd3;
    stall_cnt = 0;
    k = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      k++;
      rd_req = (k >= 5);
      if (k == 10) begin
        start = 1'b1; op = OP_DIVU; a = 32'd1; b = 32'd1;
      end
      #1;
      if (md_stall) stall_cnt++;
    end while (!done && k < 100);
    start = 1'b0;
    check("rd_req latency", 64'(k), 64'(LAT));
    check("rd_req stall cycles", 64'(stall_cnt), 64'd30);
    @(negedge clk); #1;
    check("rd_req stall released", 64'(md_stall), 64'd0);
    check("rd_req busy", 64'(busy), 64'd0);
    expect_hilo("mflo after stall", 32'h0, 32'd300);
    rd_req = 1'b0;

    // Idle again: a plain MTLO still works after everything above
    @(negedge clk); mtlo = 1'b1; wd = 32'h0BAD_F00D;
    @(negedge clk); mtlo = 1'b0; #1;
    check("mtlo late", 64'(lo), 64'h0BAD_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
